// File: rtl/if_stage_pkg.sv
// Shared pipeline package for the fetch stage: constants, the fetch-queue entry
// and the IF/ID register layout.
package if_stage_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          FQ_DEPTH         = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        epoch;
    logic        filled;
  } fq_entry_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
  } ifid_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_if.sv
// IF/ID register bundle: the fetch stage writes it, decode reads it.
interface ifid_if;

  if_stage_pkg::ifid_t data;

  modport wr (output data);
  modport rd (input  data);

endinterface

// File: rtl/fetch_queue.sv
// Two-entry in-order queue of outstanding fetches; responses fill the oldest
// unfilled entry and the head view bypasses a response landing in the head.
module fetch_queue
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic        push_epoch,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        pop,
  output logic [1:0]  count,
  output fq_entry_t   head
);

  fq_entry_t   entries_r [FQ_DEPTH];
  logic        head_r;
  logic        tail_r;
  logic        fill_r;
  logic [1:0]  count_r;

  logic        fill_occupied;
  logic        fill_en;
  logic        head_filled;
  logic        do_pop;
  logic        do_push;

  // Where the next response goes, and what the head looks like this cycle
  always_comb begin
    fill_occupied = 1'b0;
    fill_en       = 1'b0;
    head          = entries_r[head_r];
    if (count_r == 2'd2) begin
      fill_occupied = 1'b1;
    end else if (count_r == 2'd1) begin
      fill_occupied = (fill_r == head_r);
    end else begin
      fill_occupied = 1'b0;
    end
    fill_en = rsp_valid && fill_occupied && !entries_r[fill_r].filled;
    if (fill_en && (fill_r == head_r)) begin
      head.instr  = rsp_data;
      head.filled = 1'b1;
    end else begin
      head = entries_r[head_r];
    end
  end

  assign head_filled = (count_r != 2'd0) && head.filled;
  assign do_pop      = pop && head_filled;
  assign do_push     = push && ((count_r != 2'd2) || do_pop);
  assign count       = count_r;

  // Pointer, count and entry storage; a push wins over a fill of the same slot
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_r  <= 1'b0;
      tail_r  <= 1'b0;
      fill_r  <= 1'b0;
      count_r <= 2'd0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        entries_r[i] <= '0;
      end
    end else begin
      if (fill_en) begin
        entries_r[fill_r].instr  <= rsp_data;
        entries_r[fill_r].filled <= 1'b1;
        fill_r                   <= fill_r + 1'b1;
      end
      if (do_push) begin
        entries_r[tail_r] <= fq_entry_t'{pc: push_pc, instr: 32'h0000_0000,
                                         epoch: push_epoch, filled: 1'b0};
        tail_r            <= tail_r + 1'b1;
      end
      if (do_pop) begin
        head_r <= head_r + 1'b1;
      end
      count_r <= count_r + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC/epoch tracking, imem request generation and the
// IF/ID pipeline register fed from the in-order fetch queue.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  ifid_if.wr          ifid,
  output logic        ValidD
);

  logic [31:0] pcf_r;
  logic        epoch_r;
  ifid_t       ifid_r;
  logic        valid_r;

  logic [1:0]  fq_count;
  fq_entry_t   head;
  logic        head_ready;
  logic        head_match;
  logic        head_stale;
  logic        req_fire;
  logic        pop;

  assign imem_req_valid = reset && (fq_count < 2'd2);
  assign imem_req_addr  = align_word(pcf_r);
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign head_ready = (fq_count != 2'd0) && head.filled;
  assign head_match = head_ready && (head.epoch == epoch_r);
  assign head_stale = head_ready && (head.epoch != epoch_r);
  // Wrong-path entries drain even while decode is stalled
  assign pop        = head_stale || (head_match && !StallD && !FlushD);

  fetch_queue u_fetch_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (req_fire),
    .push_pc    (imem_req_addr),
    .push_epoch (epoch_r),
    .rsp_valid  (imem_rsp_valid),
    .rsp_data   (imem_rsp_data),
    .pop        (pop),
    .count      (fq_count),
    .head       (head)
  );

  // Fetch PC and epoch; a redirect overrides the sequential increment
  always_ff @(posedge clk) begin
    if (!reset) begin
      pcf_r   <= RESET_PC;
      epoch_r <= 1'b0;
    end else if (PCSrcE) begin
      pcf_r   <= align_word(PCTargetE);
      epoch_r <= ~epoch_r;
    end else if (req_fire) begin
      pcf_r   <= pcf_r + 32'd4;
    end
  end

  // IF/ID register: stall holds, flush bubbles, otherwise take a matching head
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_r <= 1'b0;
      ifid_r  <= ifid_t'{instr: NOP, PC: 32'h0000_0000, PCPlus4: 32'h0000_0000};
    end else if (StallD) begin
      valid_r <= valid_r;
      ifid_r  <= ifid_r;
    end else if (FlushD) begin
      valid_r      <= 1'b0;
      ifid_r.instr <= NOP;
    end else if (head_match) begin
      valid_r <= 1'b1;
      ifid_r  <= ifid_t'{instr: head.instr, PC: head.pc, PCPlus4: head.pc + 32'd4};
    end else begin
      valid_r      <= 1'b0;
      ifid_r.instr <= NOP;
    end
  end

  assign ifid.data = ifid_r;
  assign ValidD    = valid_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a latency-1 imem model that can be switched off
// for hand-driven responses, and hand-computed expected IF/ID contents.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        ValidD;
  logic        auto_mem;

  int checks;
  int errors;

  ifid_if ifid ();

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ifid           (ifid),
    .ValidD         (ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; the imem model answers a handshake in the following cycle.
  task automatic tick();
    logic        hs;
    logic [31:0] addr;
    #1;
    hs   = imem_req_valid && imem_req_ready;
    addr = imem_req_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_rsp_valid = hs;
      imem_rsp_data  = instr_of(addr);
    end
  endtask

  task automatic expect_ifid(input string tag, input logic [31:0] pc);
    check_eq({tag, "_valid"}, {31'd0, ValidD}, 32'd1);
    check_eq({tag, "_pc"},    ifid.data.PC, pc);
    check_eq({tag, "_instr"}, ifid.data.instr, instr_of(pc));
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b0;
    StallD         = 1'b0;
    FlushD         = 1'b0;
    PCSrcE         = 1'b0;
    PCTargetE      = 32'h0000_0000;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0000_0000;
    auto_mem       = 1'b1;

    // Reset state
    tick();
    tick();
    check_eq("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_eq("rst_validd",    {31'd0, ValidD}, 32'd0);
    check_eq("rst_instr",     ifid.data.instr, 32'h0000_0013);
    check_eq("rst_pc",        ifid.data.PC, 32'h0000_0000);
    check_eq("rst_pcplus4",   ifid.data.PCPlus4, 32'h0000_0000);
    reset = 1'b1;
    #1;
    check_eq("rel_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check_eq("rel_req_addr",  imem_req_addr, 32'h0000_0000);

    // Streaming fetch, one instruction per cycle
    tick();
    check_eq("s_first_validd", {31'd0, ValidD}, 32'd0);
    check_eq("s_next_addr",    imem_req_addr, 32'h0000_0004);
    tick();
    expect_ifid("s0", 32'h0000_0000);
    check_eq("s0_pcplus4", ifid.data.PCPlus4, 32'h0000_0004);
    tick(); expect_ifid("s4", 32'h0000_0004);
    tick(); expect_ifid("s8", 32'h0000_0008);
    tick(); expect_ifid("sc", 32'h0000_000C);

    // Stall for three cycles: hold, queue fills, requests stop
    StallD = 1'b1;
    tick();
    expect_ifid("st1", 32'h0000_000C);
    check_eq("st1_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick(); expect_ifid("st2", 32'h0000_000C);
    check_eq("st2_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick(); expect_ifid("st3", 32'h0000_000C);
    StallD = 1'b0;
    tick(); expect_ifid("rl10", 32'h0000_0010);
    tick(); expect_ifid("rl14", 32'h0000_0014);
    tick(); expect_ifid("rl18", 32'h0000_0018);

    // Redirect with two requests outstanding; both responses are stale
    auto_mem       = 1'b0;
    imem_rsp_valid = 1'b0;
    tick();
    check_eq("rd_validd0",    {31'd0, ValidD}, 32'd0);
    check_eq("rd_req_full",   {31'd0, imem_req_valid}, 32'd0);
    PCSrcE    = 1'b1;
    PCTargetE = 32'h0000_0100;
    tick();
    PCSrcE = 1'b0;
    check_eq("rd_addr",       imem_req_addr, 32'h0000_0100);
    check_eq("rd_req_valid",  {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = instr_of(32'h0000_001C);
    tick();
    check_eq("rd_stale1",     {31'd0, ValidD}, 32'd0);
    imem_rsp_data  = instr_of(32'h0000_0020);
    auto_mem       = 1'b1;
    tick();
    check_eq("rd_stale2",     {31'd0, ValidD}, 32'd0);
    tick();
    expect_ifid("rd100", 32'h0000_0100);
    check_eq("rd100_pcplus4", ifid.data.PCPlus4, 32'h0000_0104);

    // Unaligned redirect target
    PCSrcE    = 1'b1;
    PCTargetE = 32'h0000_0203;
    tick();
    PCSrcE = 1'b0;
    check_eq("ua_addr", imem_req_addr, 32'h0000_0200);
    expect_ifid("ua104", 32'h0000_0104);
    tick();
    check_eq("ua_bubble", {31'd0, ValidD}, 32'd0);
    tick();
    expect_ifid("ua200", 32'h0000_0200);

    // Address wrap at the top of memory
    PCSrcE    = 1'b1;
    PCTargetE = 32'hFFFF_FFFC;
    tick();
    PCSrcE = 1'b0;
    check_eq("wr_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    expect_ifid("wr204", 32'h0000_0204);
    tick();
    check_eq("wr_addr_zero", imem_req_addr, 32'h0000_0000);
    check_eq("wr_bubble",    {31'd0, ValidD}, 32'd0);
    tick();
    expect_ifid("wrtop", 32'hFFFF_FFFC);
    check_eq("wrtop_pcplus4", ifid.data.PCPlus4, 32'h0000_0000);
    tick();
    expect_ifid("wr0", 32'h0000_0000);

    // Flush with stall holds; flush alone bubbles and keeps the head
    FlushD = 1'b1;
    StallD = 1'b1;
    tick();
    expect_ifid("fs_hold", 32'h0000_0000);
    StallD = 1'b0;
    tick();
    check_eq("fl_validd",  {31'd0, ValidD}, 32'd0);
    check_eq("fl_instr",   ifid.data.instr, 32'h0000_0013);
    check_eq("fl_pc",      ifid.data.PC, 32'h0000_0000);
    check_eq("fl_pcplus4", ifid.data.PCPlus4, 32'h0000_0004);
    FlushD = 1'b0;
    tick(); expect_ifid("fl4", 32'h0000_0004);
    tick(); expect_ifid("fl8", 32'h0000_0008);

    // Mid-stream reset with two outstanding requests and late responses
    auto_mem       = 1'b0;
    imem_rsp_valid = 1'b0;
    tick();
    check_eq("mr_full", {31'd0, imem_req_valid}, 32'd0);
    reset = 1'b0;
    #1;
    check_eq("mr_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    check_eq("mr_validd", {31'd0, ValidD}, 32'd0);
    check_eq("mr_instr",  ifid.data.instr, 32'h0000_0013);
    check_eq("mr_pc",     ifid.data.PC, 32'h0000_0000);
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = instr_of(32'h0000_000C);
    #1;
    check_eq("mr_addr",      imem_req_addr, 32'h0000_0000);
    check_eq("mr_req_again", {31'd0, imem_req_valid}, 32'd1);
    tick();
    check_eq("mr_late1", {31'd0, ValidD}, 32'd0);
    imem_rsp_data = instr_of(32'h0000_0010);
    tick();
    check_eq("mr_late2", {31'd0, ValidD}, 32'd0);
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    auto_mem       = 1'b1;
    tick();
    check_eq("mr_wait", {31'd0, ValidD}, 32'd0);
    tick();
    expect_ifid("mr0", 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
